mem_wb_stage_hs: RTL and testbench

- Parametrised MEM/WB pipeline stage register, successor to the fixed single-register MEM/WB latch.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, a pipeline flush, and a write-back data mux folded into the capture path.
- Adds zero-register write suppression and forwarding taps for the hazard unit.
- Sits between data-memory access and the register-file write port.

---
 rtl/mem_wb_stage_hs.sv | 127 ++++++++++++
 tb/tb_mem_wb_stage_hs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_hs.sv
// MEM/WB pipeline stage with valid/ready handshake, optional skid entry,
// flush, write-back select and forwarding taps for the hazard unit.
module mem_wb_stage_hs #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int SKID         = 1,
  parameter int ZERO_PROTECT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_reg_write,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_fwd_en,
  output logic [REG_W-1:0]  o_fwd_rd,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic [1:0]        o_occupancy
);

  logic              h_v, h_rw, s_v, s_rw, rdy_q;
  logic [DATA_W-1:0] h_wb, s_wb;
  logic [REG_W-1:0]  h_rd, s_rd;

  logic              h_v_n, h_rw_n, s_v_n, s_rw_n, rdy_n;
  logic [DATA_W-1:0] h_wb_n, s_wb_n;
  logic [REG_W-1:0]  h_rd_n, s_rd_n;

  logic              accept, drain, cap_rw, zp;
  logic [DATA_W-1:0] cap_wb;

  assign o_ready = (SKID != 0) ? rdy_q : (~h_v | i_ready);
  assign accept  = i_valid & o_ready;
  assign drain   = h_v & i_ready;

  // Write-back select and r0 suppression happen once, at capture.
  assign zp     = (ZERO_PROTECT != 0) && (i_rd == '0);
  assign cap_wb = i_mem_to_reg ? i_mem_data : i_alu_data;
  assign cap_rw = i_reg_write & ~zp;

  always_comb begin
    h_v_n  = h_v;
    h_rw_n = h_rw;
    h_wb_n = h_wb;
    h_rd_n = h_rd;
    s_v_n  = s_v;
    s_rw_n = s_rw;
    s_wb_n = s_wb;
    s_rd_n = s_rd;
    if (i_flush) begin
      h_v_n = 1'b0;
      s_v_n = 1'b0;
    end else if (SKID != 0) begin
      if (drain && s_v) begin
        h_rw_n = s_rw;
        h_wb_n = s_wb;
        h_rd_n = s_rd;
        s_v_n  = 1'b0;
      end else if (accept && (drain || !h_v)) begin
        h_v_n  = 1'b1;
        h_rw_n = cap_rw;
        h_wb_n = cap_wb;
        h_rd_n = i_rd;
      end else if (accept) begin
        s_v_n  = 1'b1;
        s_rw_n = cap_rw;
        s_wb_n = cap_wb;
        s_rd_n = i_rd;
      end else if (drain) begin
        h_v_n = 1'b0;
      end
    end else begin
      if (accept) begin
        h_v_n  = 1'b1;
        h_rw_n = cap_rw;
        h_wb_n = cap_wb;
        h_rd_n = i_rd;
      end else if (drain) begin
        h_v_n = 1'b0;
      end
    end
    rdy_n = ~s_v_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_v   <= 1'b0;
      h_rw  <= 1'b0;
      h_wb  <= '0;
      h_rd  <= '0;
      s_v   <= 1'b0;
      s_rw  <= 1'b0;
      s_wb  <= '0;
      s_rd  <= '0;
      rdy_q <= 1'b1;
    end else begin
      h_v   <= h_v_n;
      h_rw  <= h_rw_n;
      h_wb  <= h_wb_n;
      h_rd  <= h_rd_n;
      s_v   <= s_v_n;
      s_rw  <= s_rw_n;
      s_wb  <= s_wb_n;
      s_rd  <= s_rd_n;
      rdy_q <= rdy_n;
    end
  end

  assign o_valid     = h_v;
  assign o_reg_write = h_v & h_rw;
  assign o_wb_data   = h_wb;
  assign o_rd        = h_rd;
  assign o_fwd_en    = h_v & h_rw;
  assign o_fwd_rd    = h_rd;
  assign o_fwd_data  = h_wb;
  assign o_occupancy = {1'b0, h_v} + {1'b0, s_v};

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// Directed bench for mem_wb_stage_hs: one SKID=1 and one SKID=0 instance
// driven from a shared stimulus, checked with immediate assertions.
module tb_mem_wb_stage_hs;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_flush, i_reg_write, i_mem_to_reg, i_ready;
  logic [31:0] i_mem_data, i_alu_data;
  logic [4:0]  i_rd;

  logic        a_ready, a_valid, a_rw, a_fen;
  logic [31:0] a_wb, a_fdata;
  logic [4:0]  a_rd, a_frd;
  logic [1:0]  a_occ;

  logic        b_ready, b_valid, b_rw, b_fen;
  logic [31:0] b_wb, b_fdata;
  logic [4:0]  b_rd, b_frd;
  logic [1:0]  b_occ;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage_hs #(.SKID(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(a_ready),
    .i_flush(i_flush), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_mem_data(i_mem_data),
    .i_alu_data(i_alu_data), .i_rd(i_rd), .o_valid(a_valid),
    .i_ready(i_ready), .o_reg_write(a_rw), .o_wb_data(a_wb),
    .o_rd(a_rd), .o_fwd_en(a_fen), .o_fwd_rd(a_frd),
    .o_fwd_data(a_fdata), .o_occupancy(a_occ)
  );

  mem_wb_stage_hs #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(b_ready),
    .i_flush(i_flush), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_mem_data(i_mem_data),
    .i_alu_data(i_alu_data), .i_rd(i_rd), .o_valid(b_valid),
    .i_ready(i_ready), .o_reg_write(b_rw), .o_wb_data(b_wb),
    .o_rd(b_rd), .o_fwd_en(b_fen), .o_fwd_rd(b_frd),
    .o_fwd_data(b_fdata), .o_occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] alu, input logic [4:0] rd);
    i_valid      = 1'b1;
    i_reg_write  = 1'b1;
    i_mem_to_reg = 1'b0;
    i_alu_data   = alu;
    i_rd         = rd;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_v"}, 32'(a_valid), 32'd0);
    chk({tag, "_rw"}, 32'(a_rw), 32'd0);
    chk({tag, "_wb"}, a_wb, 32'd0);
    chk({tag, "_rd"}, 32'(a_rd), 32'd0);
    chk({tag, "_fen"}, 32'(a_fen), 32'd0);
    chk({tag, "_frd"}, 32'(a_frd), 32'd0);
    chk({tag, "_fd"}, a_fdata, 32'd0);
    chk({tag, "_occ"}, 32'(a_occ), 32'd0);
    chk({tag, "_rdy"}, 32'(a_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_valid = 0; i_flush = 0; i_reg_write = 0;
    i_mem_to_reg = 0; i_ready = 0; i_mem_data = 0;
    i_alu_data = 0; i_rd = 0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk_zero1("reset");
    chk("reset_b_v", 32'(b_valid), 32'd0);
    chk("reset_b_rdy", 32'(b_ready), 32'd1);

    // load select
    i_valid = 1; i_reg_write = 1; i_mem_to_reg = 1;
    i_mem_data = 32'hDEADBEEF; i_alu_data = 32'h11; i_rd = 5'd7;
    i_ready = 1;
    tick;
    chk("ld_v", 32'(a_valid), 32'd1);
    chk("ld_wb", a_wb, 32'hDEADBEEF);
    chk("ld_rd", 32'(a_rd), 32'd7);
    chk("ld_rw", 32'(a_rw), 32'd1);
    chk("ld_fen", 32'(a_fen), 32'd1);
    chk("ld_frd", 32'(a_frd), 32'd7);
    chk("ld_fd", a_fdata, 32'hDEADBEEF);
    chk("ld_b_wb", b_wb, 32'hDEADBEEF);

    // zero protect
    beat(32'h5, 5'd0);
    tick;
    chk("zp_v", 32'(a_valid), 32'd1);
    chk("zp_wb", a_wb, 32'h5);
    chk("zp_rw", 32'(a_rw), 32'd0);
    chk("zp_fen", 32'(a_fen), 32'd0);
    chk("zp_b_rw", 32'(b_rw), 32'd0);
    i_valid = 0;
    tick;
    chk("drain_v", 32'(a_valid), 32'd0);
    chk("drain_rw", 32'(a_rw), 32'd0);
    chk("drain_hold", a_wb, 32'h5);
    chk("drain_occ", 32'(a_occ), 32'd0);

    // backpressure into the skid entry
    i_ready = 0;
    beat(32'h1, 5'd1);
    tick;
    chk("bp_a_occ", 32'(a_occ), 32'd1);
    chk("bp_a_rdy", 32'(a_ready), 32'd1);
    beat(32'h2, 5'd2);
    tick;
    chk("bp_b_occ", 32'(a_occ), 32'd2);
    chk("bp_b_rdy", 32'(a_ready), 32'd0);
    chk("bp_b_rd", 32'(a_rd), 32'd1);
    beat(32'h3, 5'd3);
    tick;
    chk("bp_c_occ", 32'(a_occ), 32'd2);
    chk("bp_c_rd", 32'(a_rd), 32'd1);
    tick;
    chk("bp_hold_rd", 32'(a_rd), 32'd1);
    chk("bp_hold_wb", a_wb, 32'h1);
    chk("bp_hold_rdy", 32'(a_ready), 32'd0);
    i_ready = 1;
    tick;
    chk("fifo_b_rd", 32'(a_rd), 32'd2);
    chk("fifo_b_wb", a_wb, 32'h2);
    chk("fifo_b_occ", 32'(a_occ), 32'd1);
    chk("fifo_b_rdy", 32'(a_ready), 32'd1);
    tick;
    chk("fifo_c_rd", 32'(a_rd), 32'd3);
    chk("fifo_c_v", 32'(a_valid), 32'd1);
    i_valid = 0;
    tick;
    chk("fifo_end_v", 32'(a_valid), 32'd0);
    chk("fifo_end_occ", 32'(a_occ), 32'd0);

    // flush with two held beats and an incoming one
    i_ready = 0;
    beat(32'h44, 5'd4);
    tick;
    beat(32'h55, 5'd5);
    tick;
    chk("fl_pre_occ", 32'(a_occ), 32'd2);
    beat(32'h66, 5'd6);
    i_flush = 1;
    tick;
    chk("fl_v", 32'(a_valid), 32'd0);
    chk("fl_occ", 32'(a_occ), 32'd0);
    chk("fl_rdy", 32'(a_ready), 32'd1);
    chk("fl_rw", 32'(a_rw), 32'd0);
    chk("fl_b_v", 32'(b_valid), 32'd0);
    // flush while the beat is genuinely accepted
    i_flush = 1;
    beat(32'h99, 5'd9);
    tick;
    chk("fl2_v", 32'(a_valid), 32'd0);
    chk("fl2_b_v", 32'(b_valid), 32'd0);
    i_flush = 0; i_valid = 0;
    tick;
    chk("fl2_after_v", 32'(a_valid), 32'd0);
    chk("fl2_after_occ", 32'(a_occ), 32'd0);

    // SKID=0 streaming
    i_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      beat(32'(k), 5'(k));
      tick;
      chk($sformatf("st_wb%0d", k), b_wb, 32'(k));
      chk($sformatf("st_rdy%0d", k), 32'(b_ready), 32'd1);
      chk($sformatf("st_v%0d", k), 32'(b_valid), 32'd1);
    end
    i_valid = 0;
    tick;
    chk("st_end_v", 32'(b_valid), 32'd0);

    // reset mid-operation
    i_ready = 0;
    beat(32'hA1, 5'd10);
    tick;
    beat(32'hA2, 5'd11);
    tick;
    chk("rm_pre_occ", 32'(a_occ), 32'd2);
    rst = 1;
    tick;
    rst = 0; i_valid = 0;
    chk_zero1("rm");
    chk("rm_b_v", 32'(b_valid), 32'd0);
    chk("rm_b_wb", b_wb, 32'd0);
    chk("rm_b_occ", 32'(b_occ), 32'd0);
    i_ready = 1;
    beat(32'h77, 5'd3);
    tick;
    chk("rm_first_v", 32'(a_valid), 32'd1);
    chk("rm_first_wb", a_wb, 32'h77);
    chk("rm_first_b_wb", b_wb, 32'h77);
    i_valid = 0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
